// File: rtl/voter_pkg.sv
// rtl/voter_pkg.sv - shared types and defaults for the vote collector
// Purpose : round-state enum and default sizing used by vote_collector
//           and round_timer.
// Contents: state_e (IDLE/OPEN/PRESENT), N_VOTERS_DEFAULT, TIMEOUT_DEFAULT.
package voter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        PRESENT = 2'd2
    } state_e;

    localparam int N_VOTERS_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT  = 1000;

endpackage

// File: rtl/round_timer.sv
// rtl/round_timer.sv - OPEN-phase duration counter with expiry flag
// Purpose : counts enabled cycles since the last clear; expire_o is high
//           while the count equals TIMEOUT_CYCLES-1 (the last OPEN cycle).
// Ports   : clk_i     rising-edge clock
//           rst_i     synchronous active-high reset
//           clear_i   zero the count (round start)
//           enable_i  advance the count this cycle
//           expire_o  count has reached TIMEOUT_CYCLES-1
module round_timer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + TW'(1);
        end
    end

    // The round always leaves OPEN on this value, so the count never wraps.
    assign expire_o = (count_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/vote_collector.sv
// rtl/vote_collector.sv - collects one yes/no vote per voter and presents the ballot
// Purpose : runs one voting round (IDLE -> OPEN -> PRESENT), records the
//           first single-sided vote of each voter, closes when all have
//           voted or on timeout, then holds the ballot under valid/ready.
// Ports   : clk, rst (sync, active-high), start, vote_yes/vote_no strobes,
//           ballot/ballot_valid/ballot_ready handshake, voted, busy,
//           timed_out.
// Option  : VOTE_COLLECTOR_REVOTE_EN - voters may overwrite their vote while
//           OPEN; the round then closes only on timeout.
module vote_collector
    import voter_pkg::*;
#(
    parameter int N_VOTERS       = N_VOTERS_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_yes,
    input  logic [N_VOTERS-1:0] vote_no,
    output logic [N_VOTERS-1:0] ballot,
    output logic                ballot_valid,
    input  logic                ballot_ready,
    output logic [N_VOTERS-1:0] voted,
    output logic                busy,
    output logic                timed_out
);

    state_e              state_q;
    logic [N_VOTERS-1:0] ballot_q, ballot_d;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic                ballot_valid_q;
    logic                busy_q;
    logic                timed_out_q;
    logic                all_voted_d;
    logic                timer_expire;

    round_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TW            (TW)
    ) u_round_timer (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i ((state_q == IDLE) && start),
        .enable_i(state_q == OPEN),
        .expire_o(timer_expire)
    );

    // Vote recording: a strobe counts only when exactly one of yes/no is set.
    always_comb begin
        ballot_d = ballot_q;
        voted_d  = voted_q;
        for (int i = 0; i < N_VOTERS; i++) begin
`ifdef VOTE_COLLECTOR_REVOTE_EN
            if (vote_yes[i] ^ vote_no[i]) begin
`else
            if ((vote_yes[i] ^ vote_no[i]) && !voted_q[i]) begin
`endif
                ballot_d[i] = vote_yes[i];
                voted_d[i]  = 1'b1;
            end
        end
        all_voted_d = &voted_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            ballot_q       <= '0;
            voted_q        <= '0;
            ballot_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            timed_out_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= OPEN;
                        ballot_q    <= '0;
                        voted_q     <= '0;
                        timed_out_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                OPEN: begin
                    ballot_q <= ballot_d;
                    voted_q  <= voted_d;
`ifdef VOTE_COLLECTOR_REVOTE_EN
                    if (timer_expire) begin
                        state_q        <= PRESENT;
                        ballot_valid_q <= 1'b1;
                        timed_out_q    <= !all_voted_d;
                    end
`else
                    // All-voted takes priority over a coincident timeout.
                    if (all_voted_d) begin
                        state_q        <= PRESENT;
                        ballot_valid_q <= 1'b1;
                        timed_out_q    <= 1'b0;
                    end else if (timer_expire) begin
                        state_q        <= PRESENT;
                        ballot_valid_q <= 1'b1;
                        timed_out_q    <= 1'b1;
                    end
`endif
                end
                PRESENT: begin
                    if (ballot_ready) begin
                        state_q        <= IDLE;
                        ballot_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    ballot_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    assign ballot       = ballot_q;
    assign voted        = voted_q;
    assign ballot_valid = ballot_valid_q;
    assign busy         = busy_q;
    assign timed_out    = timed_out_q;

endmodule
